exp_distance_ctrl: RTL and testbench

//  Moore FSM that sequences DATAPATH to compute distance = v * exp(x).
//  exp(x) is an 8-term Taylor sum, one term per 3-bit counter value.

---
 rtl/dp_ctrl_pkg.sv | 38 +++
 rtl/exp_ctrl_outdec.sv | 59 +++++
 rtl/exp_distance_ctrl.sv | 85 ++++++++
 tb/tb_exp_distance_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dp_ctrl_pkg.sv
// Shared definitions for the exp_distance_ctrl sequencer: state encodings,
// multiplier-select codes and the decoded control vector.
package dp_ctrl_pkg;

    localparam int ST_W = 4;

    localparam logic [ST_W-1:0] ST_IDLE     = 4'd0;
    localparam logic [ST_W-1:0] ST_INIT     = 4'd1;
    localparam logic [ST_W-1:0] ST_POW_INIT = 4'd2;
    localparam logic [ST_W-1:0] ST_MUL_POW  = 4'd3;
    localparam logic [ST_W-1:0] ST_MUL_ROM  = 4'd4;
    localparam logic [ST_W-1:0] ST_ACC      = 4'd5;
    localparam logic [ST_W-1:0] ST_DIST     = 4'd6;
    localparam logic [ST_W-1:0] ST_FIN      = 4'd7;
    localparam logic [ST_W-1:0] ST_WAIT     = 4'd8;
    localparam logic [ST_W-1:0] ST_ABORT    = 4'd9;

    localparam logic [1:0] SEL_XX      = 2'd0;
    localparam logic [1:0] SEL_ROMTERM = 2'd1;
    localparam logic [1:0] SEL_POWTERM = 2'd2;
    localparam logic [1:0] SEL_EXPV    = 2'd3;

    typedef struct packed {
        logic       busy;
        logic       s_done;
        logic       r_done;
        logic       inc_counter;
        logic       r_counter;
        logic       load_pow;
        logic [1:0] select_mult;
        logic       reset_to_one_term;
        logic       load_term;
        logic       load_exp;
        logic       r_exp;
        logic       load_distance;
    } ctrl_t;

endpackage

// File: rtl/exp_ctrl_outdec.sv
// Moore output decoder: maps the current sequencer state onto the full
// DATAPATH control vector. Unknown encodings decode to all-zero.
module exp_ctrl_outdec
    import dp_ctrl_pkg::*;
(
    input  logic [ST_W-1:0] state,
    output ctrl_t           ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_INIT: begin
                ctrl.r_counter         = 1'b1;
                ctrl.r_exp             = 1'b1;
                ctrl.reset_to_one_term = 1'b1;
                ctrl.r_done            = 1'b1;
                ctrl.busy              = 1'b1;
            end
            ST_POW_INIT: begin
                ctrl.select_mult = SEL_XX;
                ctrl.load_pow    = 1'b1;
                ctrl.busy        = 1'b1;
            end
            ST_MUL_POW: begin
                ctrl.select_mult = SEL_POWTERM;
                ctrl.load_term   = 1'b1;
                ctrl.busy        = 1'b1;
            end
            ST_MUL_ROM: begin
                ctrl.select_mult = SEL_ROMTERM;
                ctrl.load_term   = 1'b1;
                ctrl.busy        = 1'b1;
            end
            ST_ACC: begin
                ctrl.load_exp    = 1'b1;
                ctrl.inc_counter = 1'b1;
                ctrl.busy        = 1'b1;
            end
            ST_DIST: begin
                ctrl.select_mult   = SEL_EXPV;
                ctrl.load_distance = 1'b1;
                ctrl.busy          = 1'b1;
            end
            ST_FIN: begin
                ctrl.s_done = 1'b1;
                ctrl.busy   = 1'b1;
            end
            ST_ABORT: begin
                ctrl.r_counter = 1'b1;
                ctrl.r_exp     = 1'b1;
                ctrl.r_done    = 1'b1;
                ctrl.busy      = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/exp_distance_ctrl.sv
// Sequencer for distance = v * exp(x): walks DATAPATH through an 8-term
// Taylor sum (pow/rom multiply, accumulate) then the final v multiply.
module exp_distance_ctrl
    import dp_ctrl_pkg::*;
#(
    parameter int SEL_W   = 2,
    parameter int USE_POW = 1,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               asyncRst,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    input  logic               c,
    input  logic               done,
    output logic               s_done,
    output logic               r_done,
    output logic               inc_counter,
    output logic               r_counter,
    output logic               load_pow,
    output logic [SEL_W-1:0]   select_mult,
    output logic               reset_to_one_term,
    output logic               load_term,
    output logic               load_exp,
    output logic               r_exp,
    output logic               load_distance,
    output logic [STATE_W-1:0] dbg_state
);

    logic [ST_W-1:0] state;
    logic [ST_W-1:0] state_nxt;
    ctrl_t           ctrl;

    exp_ctrl_outdec u_outdec (
        .state (state),
        .ctrl  (ctrl)
    );

    // done is observed only through the host side; sequencing never needs it.
    logic unused_done;
    assign unused_done = done;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (start && !abort) state_nxt = ST_INIT;
            ST_INIT:     state_nxt = (USE_POW != 0) ? ST_POW_INIT : ST_MUL_POW;
            ST_POW_INIT: state_nxt = ST_MUL_POW;
            ST_MUL_POW:  state_nxt = ST_MUL_ROM;
            ST_MUL_ROM:  state_nxt = ST_ACC;
            ST_ACC:      state_nxt = c ? ST_DIST : ST_MUL_POW;
            ST_DIST:     state_nxt = ST_FIN;
            ST_FIN:      state_nxt = ST_WAIT;
            ST_WAIT:     if (start) state_nxt = ST_INIT;
            ST_ABORT:    state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
        // Abort overrides every transition out of a running state.
        if (abort && ctrl.busy && (state != ST_ABORT))
            state_nxt = ST_ABORT;
    end

    always_ff @(posedge clk or negedge asyncRst) begin
        if (!asyncRst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    assign busy              = ctrl.busy;
    assign s_done            = ctrl.s_done;
    assign r_done            = ctrl.r_done;
    assign inc_counter       = ctrl.inc_counter;
    assign r_counter         = ctrl.r_counter;
    assign load_pow          = ctrl.load_pow;
    assign select_mult       = SEL_W'(ctrl.select_mult);
    assign reset_to_one_term = ctrl.reset_to_one_term;
    assign load_term         = ctrl.load_term;
    assign load_exp          = ctrl.load_exp;
    assign r_exp             = ctrl.r_exp;
    assign load_distance     = ctrl.load_distance;
    assign dbg_state         = STATE_W'(state);

endmodule

// File: tb/tb_exp_distance_ctrl.sv
// Bench for exp_distance_ctrl: two instances (with and without the POW_INIT
// step) against a plan-based reference model and a tiny DATAPATH stand-in.
module tb_exp_distance_ctrl;
    import dp_ctrl_pkg::*;

    typedef enum int {M_IDLE, M_INIT, M_POW, M_MP, M_MR, M_ACC, M_DIST, M_FIN, M_WAIT, M_ABORT} step_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic asyncRst, start, abort;
    logic busy_o [2], s_done_o [2], r_done_o [2], inc_o [2], rcnt_o [2], lpow_o [2];
    logic rone_o [2], lterm_o [2], lexp_o [2], rexp_o [2], ldist_o [2];
    logic [1:0] sel_o [2];
    logic [3:0] dbg_o [2];
    logic c_i [2];
    logic force_c [2];
    logic done_i [2] = '{1'b0, 1'b0};
    logic [2:0] cnt [2] = '{3'd0, 3'd0};

    exp_distance_ctrl #(.SEL_W(2), .USE_POW(1), .STATE_W(4)) dut_a (
        .clk(clk), .asyncRst(asyncRst), .start(start), .abort(abort), .busy(busy_o[0]),
        .c(c_i[0]), .done(done_i[0]), .s_done(s_done_o[0]), .r_done(r_done_o[0]),
        .inc_counter(inc_o[0]), .r_counter(rcnt_o[0]), .load_pow(lpow_o[0]),
        .select_mult(sel_o[0]), .reset_to_one_term(rone_o[0]), .load_term(lterm_o[0]),
        .load_exp(lexp_o[0]), .r_exp(rexp_o[0]), .load_distance(ldist_o[0]), .dbg_state(dbg_o[0]));

    exp_distance_ctrl #(.SEL_W(2), .USE_POW(0), .STATE_W(4)) dut_b (
        .clk(clk), .asyncRst(asyncRst), .start(start), .abort(abort), .busy(busy_o[1]),
        .c(c_i[1]), .done(done_i[1]), .s_done(s_done_o[1]), .r_done(r_done_o[1]),
        .inc_counter(inc_o[1]), .r_counter(rcnt_o[1]), .load_pow(lpow_o[1]),
        .select_mult(sel_o[1]), .reset_to_one_term(rone_o[1]), .load_term(lterm_o[1]),
        .load_exp(lexp_o[1]), .r_exp(rexp_o[1]), .load_distance(ldist_o[1]), .dbg_state(dbg_o[1]));

    // DATAPATH stand-in: term counter with carry, and the done flag.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rcnt_o[i])     cnt[i] <= 3'd0;
            else if (inc_o[i]) cnt[i] <= cnt[i] + 3'd1;
            if (r_done_o[i])      done_i[i] <= 1'b0;
            else if (s_done_o[i]) done_i[i] <= 1'b1;
        end
    end
    assign c_i[0] = (cnt[0] == 3'd7) | force_c[0];
    assign c_i[1] = (cnt[1] == 3'd7) | force_c[1];

    int total = 0;
    int bad = 0;
    step_t cur [2];
    step_t plan [2][32];
    int pidx [2], plen [2], lat [2], nexp [2];
    logic exp_done [2];
    logic prev_done [2];
    int npow_b = 0;

    // {busy,s_done,r_done,inc,r_counter,load_pow,sel[1:0],one_term,load_term,load_exp,r_exp,load_distance}
    function automatic logic [12:0] exp_vec(input step_t s);
        case (s)
            M_INIT:  return 13'b1_0_1_0_1_0_00_1_0_0_1_0;
            M_POW:   return 13'b1_0_0_0_0_1_00_0_0_0_0_0;
            M_MP:    return 13'b1_0_0_0_0_0_10_0_1_0_0_0;
            M_MR:    return 13'b1_0_0_0_0_0_01_0_1_0_0_0;
            M_ACC:   return 13'b1_0_0_1_0_0_00_0_0_1_0_0;
            M_DIST:  return 13'b1_0_0_0_0_0_11_0_0_0_0_1;
            M_FIN:   return 13'b1_1_0_0_0_0_00_0_0_0_0_0;
            M_ABORT: return 13'b1_0_1_0_1_0_00_0_0_0_1_0;
            default: return 13'b0;
        endcase
    endfunction

    function automatic logic [3:0] exp_state(input step_t s);
        case (s)
            M_INIT:  return ST_INIT;
            M_POW:   return ST_POW_INIT;
            M_MP:    return ST_MUL_POW;
            M_MR:    return ST_MUL_ROM;
            M_ACC:   return ST_ACC;
            M_DIST:  return ST_DIST;
            M_FIN:   return ST_FIN;
            M_WAIT:  return ST_WAIT;
            M_ABORT: return ST_ABORT;
            default: return ST_IDLE;
        endcase
    endfunction

    function automatic logic [12:0] obs_vec(input int i);
        return {busy_o[i], s_done_o[i], r_done_o[i], inc_o[i], rcnt_o[i], lpow_o[i],
                sel_o[i], rone_o[i], lterm_o[i], lexp_o[i], rexp_o[i], ldist_o[i]};
    endfunction

    task automatic accept(input int i);
        plen[i] = 0;
        plan[i][plen[i]++] = M_INIT;
        if (i == 0) plan[i][plen[i]++] = M_POW;
        for (int k = 0; k < 8; k++) begin
            plan[i][plen[i]++] = M_MP;
            plan[i][plen[i]++] = M_MR;
            plan[i][plen[i]++] = M_ACC;
        end
        plan[i][plen[i]++] = M_DIST;
        plan[i][plen[i]++] = M_FIN;
        cur[i] = plan[i][0];
        pidx[i] = 1;
        lat[i] = 0;
        nexp[i] = 0;
    endtask

    task automatic advance(input logic st, input logic ab);
        for (int i = 0; i < 2; i++) begin
            if (cur[i] == M_FIN) exp_done[i] = 1'b1;
            else if (cur[i] == M_INIT || cur[i] == M_ABORT) exp_done[i] = 1'b0;
            case (cur[i])
                M_IDLE:  if (st && !ab) accept(i);
                M_WAIT:  if (st) accept(i);
                M_ABORT: cur[i] = M_IDLE;
                default: begin
                    if (ab) cur[i] = M_ABORT;
                    else if (pidx[i] < plen[i]) cur[i] = plan[i][pidx[i]++];
                    else cur[i] = M_WAIT;
                end
            endcase
        end
    endtask

    task automatic check();
        for (int i = 0; i < 2; i++) begin
            total++;
            assert (obs_vec(i) === exp_vec(cur[i])) else begin
                bad++; $error("FAIL ctrl[%0d] step=%0d got=%b want=%b", i, cur[i], obs_vec(i), exp_vec(cur[i]));
            end
            total++;
            assert (dbg_o[i] === exp_state(cur[i])) else begin
                bad++; $error("FAIL dbg_state[%0d] got=%0d want=%0d", i, dbg_o[i], exp_state(cur[i]));
            end
            total++;
            assert (done_i[i] === exp_done[i]) else begin
                bad++; $error("FAIL done[%0d] got=%b want=%b", i, done_i[i], exp_done[i]);
            end
            if (lexp_o[i]) nexp[i]++;
            if (i == 1 && lpow_o[i]) npow_b++;
            if (done_i[i] && !prev_done[i]) begin
                total++;
                assert (lat[i] == ((i == 0) ? 29 : 28)) else begin
                    bad++; $error("FAIL latency[%0d] got=%0d want=%0d", i, lat[i], (i == 0) ? 29 : 28);
                end
                total++;
                assert (nexp[i] == 8) else begin
                    bad++; $error("FAIL load_exp_count[%0d] got=%0d want=8", i, nexp[i]);
                end
            end
            prev_done[i] = done_i[i];
        end
    endtask

    task automatic check_reset();
        for (int i = 0; i < 2; i++) begin
            total++;
            assert (obs_vec(i) === 13'b0 && dbg_o[i] === ST_IDLE) else begin
                bad++; $error("FAIL reset[%0d] got=%b/%0d want=0/%0d", i, obs_vec(i), dbg_o[i], ST_IDLE);
            end
        end
    endtask

    task automatic step(input logic st, input logic ab);
        start = st;
        abort = ab;
        for (int i = 0; i < 2; i++)
            force_c[i] = (cur[i] != M_ACC) && ($urandom_range(0, 3) == 0);
        advance(st, ab);
        @(posedge clk);
        @(negedge clk);
        lat[0]++;
        lat[1]++;
        check();
    endtask

    int ab_at;

    initial begin
        asyncRst = 1'b0; start = 1'b1; abort = 1'b0;
        for (int i = 0; i < 2; i++) begin
            force_c[i] = 1'b0; cur[i] = M_IDLE; exp_done[i] = 1'b0; prev_done[i] = 1'b0;
            pidx[i] = 0; plen[i] = 0; lat[i] = 0; nexp[i] = 0;
        end
        repeat (2) @(negedge clk);
        check_reset();
        asyncRst = 1'b1;

        // single operation, then back-to-back restart from WAIT
        step(1'b1, 1'b0);
        repeat (30) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (31) step(1'b0, 1'b0);

        // abort at the third MUL_ROM of the POW instance
        step(1'b1, 1'b0);
        repeat (9) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b1);

        // start held through a run
        repeat (20) step(1'b1, 1'b0);
        repeat (40) step(1'b0, 1'b0);

        // asynchronous reset mid-run
        step(1'b1, 1'b0);
        repeat (6) step(1'b0, 1'b0);
        #2 asyncRst = 1'b0;
        #1 check_reset();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cur[i] = M_IDLE; force_c[i] = 1'b0;
        end
        @(negedge clk);
        check_reset();
        asyncRst = 1'b1;
        step(1'b0, 1'b0);

        // randomized episodes
        repeat (12) begin
            repeat ($urandom_range(0, 3)) step(1'b0, ($urandom_range(0, 1) == 1));
            step(1'b1, ($urandom_range(0, 3) == 0));
            ab_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 30)) : 99;
            for (int k = 1; k <= 32; k++)
                step(($urandom_range(0, 4) == 0), (k == ab_at));
            repeat (3) step(1'b0, 1'b0);
        end

        total++;
        assert (npow_b == 0) else begin
            bad++; $error("FAIL load_pow_without_pow got=%0d want=0", npow_b);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
